// File: rtl/fetch_unit.sv
// fetch_unit: RISC-V fetch stage with 2-deep instruction buffer, in-order imem responses and redirect flush.
// Define FETCH_MISALIGN_TRAP_EN to halt on misaligned redirects instead of forcing word alignment.
module fetch_unit #(
    parameter int ADDR_W = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              ImemReq,
    output logic [ADDR_W-1:0] ImemAddr,
    input  logic              ImemGnt,
    input  logic              ImemRvalid,
    input  logic [31:0]       ImemRdata,
    input  logic              Redirect,
    input  logic [ADDR_W-1:0] RedirectPc,
    output logic              InstValid,
    input  logic              InstReady,
    output logic [ADDR_W-1:0] InstPc,
    output logic [31:0]       Instruction,
    output logic [0:4]        OpCode,
    output logic [0:11]       InstructionP1,
    output logic [0:4]        InstructionP2,
    output logic              MisalignErr
);
    logic [ADDR_W-1:0] fetch_pc, resp_pc, pc0, pc1, tgt;
    logic [31:0]       w0, w1;
    logic [1:0]        occ, outst, drop, outst_nx, slot;
    logic              halt, gnt, rsp, push, pop, mis;
    always_comb begin
        ImemReq       = !halt && outst != 2'd2 && ({1'b0, occ} + {1'b0, outst} - {1'b0, drop}) < 3'd2;
        ImemAddr      = fetch_pc;
        InstValid     = occ != 2'd0;
        InstPc        = pc0;
        Instruction   = w0;
        OpCode        = w0[6:2];
        InstructionP1 = w0[31:20];
        InstructionP2 = w0[11:7];
        MisalignErr   = halt;
        gnt           = ImemReq && ImemGnt;
        rsp           = ImemRvalid && outst != 2'd0;
        push          = rsp && drop == 2'd0 && !Redirect && !halt;
        pop           = InstValid && InstReady;
        outst_nx      = outst + {1'b0, gnt} - {1'b0, rsp};
        slot          = occ - {1'b0, pop};
`ifdef FETCH_MISALIGN_TRAP_EN
        tgt           = RedirectPc;
        mis           = RedirectPc[1:0] != 2'b00;
`else
        tgt           = RedirectPc & ~ADDR_W'(3);
        mis           = 1'b0;
`endif
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            pc0      <= '0;
            pc1      <= '0;
            w0       <= '0;
            w1       <= '0;
            occ      <= '0;
            outst    <= '0;
            drop     <= '0;
            halt     <= 1'b0;
        end else begin
            outst <= outst_nx;
            occ   <= occ + {1'b0, push} - {1'b0, pop};
            if (gnt) fetch_pc <= fetch_pc + ADDR_W'(4);
            if (rsp && drop != 2'd0) drop <= drop - 2'd1;
            if (push) resp_pc <= resp_pc + ADDR_W'(4);
            if (pop) begin
                pc0 <= pc1;
                w0  <= w1;
            end
            // write slot is computed after this cycle's pop has shifted the buffer
            if (push && slot == 2'd0) begin
                pc0 <= resp_pc;
                w0  <= ImemRdata;
            end
            if (push && slot != 2'd0) begin
                pc1 <= resp_pc;
                w1  <= ImemRdata;
            end
            if (Redirect) begin
                occ      <= '0;
                fetch_pc <= tgt;
                resp_pc  <= tgt;
                drop     <= outst_nx;
                halt     <= mis;
            end
        end
    end
endmodule
